// File: rtl/ecp5_io_pkg.sv
// Shared constants and elaboration helpers for the ECP5 DDR input capture blocks.
package ecp5_io_pkg;

  localparam int BEATS_PER_CLK = 2;

  // Bits needed to hold 0..n-1. The result is at least 1, so a single-state counter still has a legal width.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int width, input int beats, input int prim_lat);
    return (width >= 1) && (width <= 32) &&
           (beats >= BEATS_PER_CLK) && ((beats % BEATS_PER_CLK) == 0) &&
           (prim_lat >= 1);
  endfunction

endpackage

// File: rtl/ecp5_iddr_lane.sv
// One DDR input lane with IDDRX1F timing: rise and fall beats of a pair
// appear together on q0/q1 PRIM_LAT rising edges after the rise beat was sampled.
module ecp5_iddr_lane #(
  parameter int PRIM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q0,
  output logic q1
);

  logic                rise_cap;
  logic                fall_cap;
  logic [PRIM_LAT-1:0] q0_pipe;
  logic [PRIM_LAT-1:0] q1_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rise_cap <= 1'b0;
    else     rise_cap <= d;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_cap <= 1'b0;
    else     fall_cap <= d;
  end

  // Bit 0 is the newest pair; the top bit is the one presented on q0/q1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_pipe <= '0;
      q1_pipe <= '0;
    end else begin
      q0_pipe <= PRIM_LAT'({q0_pipe, rise_cap});
      q1_pipe <= PRIM_LAT'({q1_pipe, fall_cap});
    end
  end

  assign q0 = q0_pipe[PRIM_LAT-1];
  assign q1 = q1_pipe[PRIM_LAT-1];

endmodule

// File: rtl/ecp5_iddr_deser.sv
// WIDTH-lane DDR capture and deserialiser: orders rise/fall beats by the alignment
// select and packs accepted pairs into BEATS-beat words with a one-cycle valid strobe.
module ecp5_iddr_deser
  import ecp5_io_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BEATS    = 4,
  parameter int PRIM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   en,
  input  logic                   align_fall,
  output logic [WIDTH*BEATS-1:0] dout,
  output logic                   dout_valid,
  output logic                   err_partial,
  output logic                   busy
);

  localparam int PAIRS  = BEATS / BEATS_PER_CLK;
  localparam int CW     = clog2_min1(PAIRS);
  localparam int PAIR_W = BEATS_PER_CLK * WIDTH;
  localparam int EN_W   = PRIM_LAT + 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  if (!params_ok(WIDTH, BEATS, PRIM_LAT)) begin : g_bad_params
    $error("ecp5_iddr_deser: unsupported WIDTH/BEATS/PRIM_LAT combination");
  end

  logic                   iddr_rst;
  logic [WIDTH-1:0]       q_rise;
  logic [WIDTH-1:0]       q_fall;
  logic [WIDTH-1:0]       held_f;
  logic [EN_W-1:0]        en_pipe;
  logic                   en_d;
  logic                   en_dd;
  logic [CW-1:0]          cnt;
  logic                   align_q;
  logic                   align_sel;
  logic                   take;
  logic [WIDTH-1:0]       beat_lo;
  logic [WIDTH-1:0]       beat_hi;
  logic [WIDTH*BEATS-1:0] pack;
  logic [WIDTH*BEATS-1:0] next_pack;

  assign iddr_rst = ~rst_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ecp5_iddr_lane #(.PRIM_LAT(PRIM_LAT)) u_lane (
      .clk (clk),
      .rst (iddr_rst),
      .d   (din[i]),
      .q0  (q_rise[i]),
      .q1  (q_fall[i])
    );
  end

  // Stage 0 holds en from the rise edge of a pair; the top stage lines up with that pair on q_rise/q_fall.
  assign en_d = en_pipe[PRIM_LAT];

  // Alignment is taken from the pin at the first pair of a word and frozen until the word ends.
  assign align_sel = (cnt == '0) ? align_fall : align_q;
  assign take      = align_sel ? en_dd : en_d;
  assign beat_lo   = align_sel ? held_f : q_rise;
  assign beat_hi   = align_sel ? q_rise : q_fall;
  assign busy      = (cnt != '0);

  always_comb begin
    next_pack = pack;
    next_pack[int'(cnt)*PAIR_W +: PAIR_W] = {beat_hi, beat_lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe     <= '0;
      en_dd       <= 1'b0;
      held_f      <= '0;
      cnt         <= '0;
      align_q     <= 1'b0;
      pack        <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      en_pipe     <= EN_W'({en_pipe, en});
      en_dd       <= en_d;
      held_f      <= q_fall;
      dout_valid  <= 1'b0;
      err_partial <= 1'b0;
      if (take) begin
        pack <= next_pack;
        if (cnt == '0) align_q <= align_fall;
        if (cnt == LAST) begin
          cnt        <= '0;
          dout       <= next_pack;
          dout_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (cnt != '0) begin
        cnt         <= '0;
        err_partial <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecp5_iddr_deser.sv
// Bench for ecp5_iddr_deser: BEATS=4 and BEATS=2 instances share one byte-wide DDR stimulus
// and are compared cycle by cycle against a beat-queue reference model.
module tb_ecp5_iddr_deser;

  localparam int N = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        en = 1'b0;
  logic        align_fall = 1'b0;
  logic [31:0] dout4;
  logic        v4, e4, b4;
  logic [15:0] dout2;
  logic        v2, e2, b2;

  always #5 clk = ~clk;

  ecp5_iddr_deser #(.WIDTH(8), .BEATS(4), .PRIM_LAT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .align_fall(align_fall),
    .dout(dout4), .dout_valid(v4), .err_partial(e4), .busy(b4)
  );

  ecp5_iddr_deser #(.WIDTH(8), .BEATS(2), .PRIM_LAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .align_fall(align_fall),
    .dout(dout2), .dout_valid(v2), .err_partial(e2), .busy(b2)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  r_a [N];
  logic [7:0]  f_a [N];
  bit          en_a [N];
  logic [31:0] dout_m [2];
  int          sess = 0;
  int          fv4, lv4, nv4, nv2, ne4, nb2;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clear_stim();
    for (int t = 0; t < N; t++) begin
      r_a[t]  = 8'($urandom);
      f_a[t]  = 8'($urandom);
      en_a[t] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_val({tag, "_dout4"}, dout4, 32'h0);
    chk_val({tag, "_valid4"}, 32'(v4), 32'h0);
    chk_val({tag, "_err4"}, 32'(e4), 32'h0);
    chk_val({tag, "_busy4"}, 32'(b4), 32'h0);
    chk_val({tag, "_dout2"}, 32'(dout2), 32'h0);
    chk_val({tag, "_valid2"}, 32'(v2), 32'h0);
    chk_val({tag, "_err2"}, 32'(e2), 32'h0);
    chk_val({tag, "_busy2"}, 32'(b2), 32'h0);
  endtask

  // Reference: a pair qualified by en in input cycle j contributes two beats
  // (r_j,f_j, or f_j,r_(j+1) when fall-aligned) and is seen on the outputs after edge j+lat.
  task automatic run_session(input bit al, input int rst_at);
    int          lat;
    int          b;
    int          j;
    bit          ev [2][N];
    bit          ee [2][N];
    bit          eb [2][N];
    logic [31:0] ed [2][N];
    logic [31:0] w;
    logic [7:0]  q [$];
    string       tg;

    align_fall = al;
    lat = 2 + int'(al);
    for (int d = 0; d < 2; d++) begin
      b = (d == 0) ? 4 : 2;
      q.delete();
      for (int t = 0; t < N; t++) begin
        ev[d][t] = 1'b0;
        ee[d][t] = 1'b0;
        j = t - lat;
        if (j >= 0) begin
          if (en_a[j]) begin
            if (al) begin
              q.push_back(f_a[j]);
              q.push_back(r_a[j+1]);
            end else begin
              q.push_back(r_a[j]);
              q.push_back(f_a[j]);
            end
            if (q.size() == b) begin
              w = '0;
              for (int i = 0; i < b; i++) w = w | (32'(q[i]) << (8 * i));
              dout_m[d] = w;
              ev[d][t] = 1'b1;
              q.delete();
            end
          end else if (q.size() != 0) begin
            ee[d][t] = 1'b1;
            q.delete();
          end
        end
        ed[d][t] = dout_m[d];
        eb[d][t] = (q.size() != 0);
      end
    end

    fv4 = -1; lv4 = -1; nv4 = 0; nv2 = 0; ne4 = 0; nb2 = 0;
    for (int t = 0; t < N; t++) begin
      din = r_a[t];
      en  = en_a[t];
      @(posedge clk);
      #1;
      tg = $sformatf("s%0d_t%0d", sess, t);
      chk_val({tg, "_valid4"}, 32'(v4), 32'(ev[0][t]));
      chk_val({tg, "_err4"}, 32'(e4), 32'(ee[0][t]));
      chk_val({tg, "_busy4"}, 32'(b4), 32'(eb[0][t]));
      chk_val({tg, "_dout4"}, dout4, ed[0][t]);
      chk_val({tg, "_valid2"}, 32'(v2), 32'(ev[1][t]));
      chk_val({tg, "_err2"}, 32'(e2), 32'(ee[1][t]));
      chk_val({tg, "_busy2"}, 32'(b2), 32'(eb[1][t]));
      chk_val({tg, "_dout2"}, 32'(dout2), ed[1][t]);
      if (v4) begin
        nv4++;
        if (fv4 < 0) fv4 = t;
        lv4 = t;
      end
      if (v2) nv2++;
      if (e4) ne4++;
      if (b2) nb2++;
      if (t == rst_at) begin
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk_zero($sformatf("s%0d_rst", sess));
        dout_m[0] = '0;
        dout_m[1] = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      #1 din = f_a[t];
      @(negedge clk);
      #1;
    end
    sess++;
  endtask

  initial begin
    dout_m[0] = '0;
    dout_m[1] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("por");
    rst_n = 1'b1;

    // Rise-aligned single word
    clear_stim();
    r_a[0] = 8'h11; f_a[0] = 8'h22; r_a[1] = 8'h33; f_a[1] = 8'h44;
    en_a[0] = 1'b1; en_a[1] = 1'b1;
    run_session(1'b0, -1);
    chk_val("t1_dout", dout4, 32'h44332211);
    chk_val("t1_first_valid_edge", 32'(fv4), 32'd3);
    chk_val("t1_nvalid", 32'(nv4), 32'd1);
    chk_val("t1_nerr", 32'(ne4), 32'd0);

    // Fall-aligned word, one cycle more latency
    clear_stim();
    f_a[0] = 8'h11; r_a[1] = 8'h22; f_a[1] = 8'h33; r_a[2] = 8'h44; f_a[2] = 8'h55;
    en_a[0] = 1'b1; en_a[1] = 1'b1; en_a[2] = 1'b1;
    run_session(1'b1, -1);
    chk_val("t2_dout", dout4, 32'h44332211);
    chk_val("t2_first_valid_edge", 32'(fv4), 32'd4);
    chk_val("t2_nvalid", 32'(nv4), 32'd1);

    // Back-to-back words
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      r_a[i]  = 8'(2 * i);
      f_a[i]  = 8'(2 * i + 1);
      en_a[i] = 1'b1;
    end
    run_session(1'b0, -1);
    chk_val("t3_dout_last", dout4, 32'h07060504);
    chk_val("t3_first_valid_edge", 32'(fv4), 32'd3);
    chk_val("t3_strobe_spacing", 32'(lv4 - fv4), 32'd2);
    chk_val("t3_nvalid4", 32'(nv4), 32'd2);
    chk_val("t3_nvalid2", 32'(nv2), 32'd4);

    // Partial word discarded
    clear_stim();
    r_a[0] = 8'hAA; f_a[0] = 8'hBB; en_a[0] = 1'b1;
    run_session(1'b0, -1);
    chk_val("t4_nerr", 32'(ne4), 32'd1);
    chk_val("t4_nvalid", 32'(nv4), 32'd0);
    chk_val("t4_dout_kept", dout4, 32'h07060504);

    // BEATS=2 instance strobes on every pair
    clear_stim();
    for (int i = 0; i < 3; i++) en_a[i] = 1'b1;
    run_session(1'b0, -1);
    chk_val("t6_nvalid2", 32'(nv2), 32'd3);
    chk_val("t6_busy2_seen", 32'(nb2), 32'd0);
    chk_val("t6_nvalid4", 32'(nv4), 32'd1);
    chk_val("t6_nerr4", 32'(ne4), 32'd1);

    // Reset while the 4-beat word is half full
    clear_stim();
    en_a[0] = 1'b1; en_a[1] = 1'b1;
    run_session(1'b0, 2);
    chk_val("t5_dout_after_rst", dout4, 32'h0);
    clear_stim();
    en_a[2] = 1'b1; en_a[3] = 1'b1;
    run_session(1'b0, -1);
    chk_val("t5_nvalid_after", 32'(nv4), 32'd1);

    for (int s = 0; s < 10; s++) begin
      clear_stim();
      for (int t = 0; t < N - 6; t++) en_a[t] = ($urandom_range(0, 3) != 0);
      run_session(1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
